// File: rtl/majority_vote_scheduler.sv
// rtl/majority_vote_scheduler.sv - round-robin front end sharing one registered 5-input majority voter
// Optional saturating response counter on vote_cnt: define MAJ_SCHED_CNT_EN.
module majority_vote_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [5*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_vote,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       vote_cnt
);

  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, id_q, grant_idx;
  logic [4:0]     op_q, grant_word;
  logic [IDW:0]   cand;
  logic           grant_found, accept, rsp_fire;

  function automatic logic majority5(input logic [4:0] w);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int b = 0; b < 5; b++) cnt = cnt + {2'b00, w[b]};
    return cnt >= 3'd3;
  endfunction

  // Rotating priority search starting at ptr, wrapping modulo NREQ
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    grant_word = 5'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) grant_word = req_data[5*i +: 5];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    rsp_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst && grant_found) begin
          for (int i = 0; i < NREQ; i++) req_ready[i] = (grant_idx == IDW'(i));
          accept  = 1'b1;
          state_d = EVAL;
        end
      end
      EVAL: state_d = HOLD;
      HOLD: begin
        if (rsp_ready) begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      op_q      <= 5'd0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_vote  <= 1'b0;
      rsp_id    <= '0;
    end else begin
      if (accept) begin
        op_q <= grant_word;
        id_q <= grant_idx;
      end
      if (state_q == EVAL) begin
        rsp_vote  <= majority5(op_q);
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end
      // Next search starts just past the requester that was served
      if (rsp_fire) begin
        rsp_valid <= 1'b0;
        ptr_q     <= (id_q == IDW'(NREQ-1)) ? '0 : id_q + IDW'(1);
      end
    end
  end

`ifdef MAJ_SCHED_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                               cnt_q <= 16'h0000;
    else if (rsp_fire && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end

  assign vote_cnt = cnt_q;
`else
  assign vote_cnt = 16'h0000;
`endif

endmodule
